sif_initiator: RTL and testbench
================================

Name: sif_initiator

Overview:
- Command-driven initiator for the small-interface (SIF) xa-side bus; the SIF target block is the responder.
- Accepts write/read commands through a valid/ready port and buffers them in a small FIFO.
- Drives single-cycle xa_wr_s/xa_rd_s strobes with address and write data.
- Captures xa_data_rd one cycle after each read strobe and returns it on a response port. Sits between a test sequencer or CPU-side logic and the SIF block.

Parameters:
- CMD_DEPTH, 4, command FIFO depth (power of two, at least 2)
- AW, 16, address width (matches the SIF bus)
- DW, 16, data width (matches the SIF bus)

Ports:
- clk  in  1  clock
- rst  in  1  reset; one clock, synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  FIFO can accept (not full)
- cmd_rd  in  1  1=read, 0=write
- cmd_addr  in  AW  command address
- cmd_data  in  DW  write data (ignored for reads)
- rsp_valid  out  1  one-cycle pulse, read data available
- rsp_data  out  DW  read data
- rsp_addr  out  AW  address of the returned read
- xa_wr_s  out  1  SIF write strobe
- xa_rd_s  out  1  SIF read strobe
- xa_addr  out  AW  SIF address
- xa_data_wr  out  DW  SIF write data
- xa_data_rd  in  DW  SIF read data, valid the cycle after xa_rd_s
- busy  out  1  FIFO non-empty or FSM not IDLE
- wr_cnt  out  16  writes issued, wraps at 0xFFFF->0
- rd_cnt  out  16  reads completed, wraps at 0xFFFF->0

Behaviour:
- Reset values:
  - All outputs 0, except cmd_ready=1.
  - FIFO flushed, FSM to IDLE.
  - Reset mid-read discards the in-flight read: no rsp_valid follows.
- Handshake and FIFO:
  - Push on cmd_valid&&cmd_ready.
  - cmd_ready=!full, registered from current occupancy. No bypass when full, even if a pop happens in the same cycle.
  - Push and pop in the same cycle (not full) keeps occupancy unchanged.
- FSM states: IDLE, ISSUE, RD_WAIT, RD_RSP.
  - IDLE: FIFO non-empty -> pop head, go to ISSUE.
  - ISSUE: registered outputs drive xa_addr and xa_data_wr. The strobe for the command's type is 1 for exactly this cycle.
  - ISSUE, write: wr_cnt increments. If FIFO non-empty, pop again and stay in ISSUE (back-to-back writes, one per cycle); else go to IDLE.
  - ISSUE, read: go to RD_WAIT. No pop.
  - RD_WAIT: strobes 0. Sample xa_data_rd into rsp_data and copy the address to rsp_addr. Go to RD_RSP.
  - RD_RSP: rsp_valid=1 for one cycle, rd_cnt increments. Pop the next command if present (-> ISSUE), else go to IDLE.
- Latency:
  - Command accepted in cycle T (empty FIFO, IDLE) -> strobe in T+2.
  - Read strobe in cycle S -> rsp_valid in S+2.
  - Reads occupy the bus for 3 cycles, writes 1.
- Strobe rules:
  - xa_wr_s and xa_rd_s are never both 1.
  - xa_addr and xa_data_wr hold their last values when idle.
  - xa_data_wr is not updated for reads.
- No response backpressure: rsp_valid is a pulse and the consumer must take it.

Optional Feature:
- Macro: SIF_INIT_CHECK_EN
- Defined:
  - Adds output rsp_err (1 bit) and err_cnt (8 bits, saturating at 0xFF).
  - In RD_WAIT, compare xa_data_rd against sif_pkg::sif_scramble(addr), which swaps in addr[8]^addr[4] at bit 8 and addr[7]^addr[5] at bit 7; all other bits pass through.
  - On mismatch, rsp_err=1 alongside rsp_valid and err_cnt increments.
  - Both reset to 0.
- Undefined: ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- sif_pkg contains:
  - SIF_AW and SIF_DW constants
  - the sif_cmd_t struct (rd, addr, data)
  - the state enum sif_init_state_e
  - the function sif_scramble
- Sub-module sif_cmd_fifo: synchronous FIFO of sif_cmd_t, depth CMD_DEPTH, with full/empty flags and the same synchronous active-high reset.

Test Plan:
- Reset: assert rst for 3 cycles while a read is in flight -> no rsp_valid; all outputs 0, cmd_ready=1; wr_cnt=rd_cnt=0.
- Single write: cmd addr 0x1234 data 0xBEEF -> xa_wr_s high exactly 1 cycle at T+2 with xa_addr=0x1234 and xa_data_wr=0xBEEF; wr_cnt=1.
- Reads against the SIF model:
  - 0x05DE -> rsp_data 0x04DE
  - 0x0463 -> rsp_data 0x04E3
  - 0x1305 -> rsp_data 0x1305
  - each response arrives 2 cycles after its strobe with matching rsp_addr; rd_cnt=3.
- FIFO full: hold cmd_valid for 6 writes while stalled behind a read -> cmd_ready drops after 4 entries; all 6 are issued in order; writes go back-to-back with no gaps.
- Mixed order: write, read, write -> strobes never overlap; the second write's strobe is in the RD_RSP+1 cycle; wr_cnt wraps from 0xFFFF to 0 when preloaded by 65535 writes.
- With SIF_INIT_CHECK_EN: the responder model corrupts bit 0 on address 0x0463 -> rsp_err=1, err_cnt=1; a clean read gives rsp_err=0.

Source files
------------

// File: rtl/sif_pkg.sv
// Shared types and helpers for the SIF bus initiator: bus widths, command
// record, FSM state encoding and the responder's address scramble.
package sif_pkg;

  localparam int SIF_AW    = 16;
  localparam int SIF_DW    = 16;
  localparam int SIF_CMD_W = 1 + SIF_AW + SIF_DW;

  typedef struct packed {
    logic              rd;
    logic [SIF_AW-1:0] addr;
    logic [SIF_DW-1:0] data;
  } sif_cmd_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RD_WAIT = 2'd2,
    RD_RSP  = 2'd3
  } sif_init_state_e;

  // Read data the SIF target returns for an address: bits 8 and 7 are
  // folded with bits 4 and 5, every other bit passes through.
  function automatic logic [SIF_DW-1:0] sif_scramble(input logic [SIF_AW-1:0] addr);
    logic [SIF_DW-1:0] r;
    r    = addr;
    r[8] = addr[8] ^ addr[4];
    r[7] = addr[7] ^ addr[5];
    return r;
  endfunction

endpackage

// File: rtl/sif_cmd_fifo.sv
// Synchronous command FIFO for the SIF initiator; head is read
// combinationally so the FSM can pop and launch in the same cycle.
module sif_cmd_fifo
  import sif_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic [SIF_CMD_W-1:0] cmd_i,
  input  logic                 pop_i,
  output logic [SIF_CMD_W-1:0] head_o,
  output logic                 full_o,
  output logic                 empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [SIF_CMD_W-1:0] mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PW:0]          count_q, count_d;
  logic                 do_push, do_pop;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

  // Full blocks the push even when a pop happens in the same cycle.
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(do_push);
    rd_ptr_d = rd_ptr_q + PW'(do_pop);
    count_d  = count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= cmd_i;
    end
  end

endmodule

// File: rtl/sif_initiator.sv
// Command-driven initiator for the SIF xa-side bus: queues commands, issues
// one-cycle strobes, returns read data. Optional SIF_INIT_CHECK_EN adds a
// read-data integrity check (rsp_err, err_cnt).
module sif_initiator
  import sif_pkg::*;
#(
  parameter int CMD_DEPTH = 4,
  parameter int AW        = SIF_AW,
  parameter int DW        = SIF_DW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic          cmd_rd,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic [AW-1:0] rsp_addr,
  output logic          xa_wr_s,
  output logic          xa_rd_s,
  output logic [AW-1:0] xa_addr,
  output logic [DW-1:0] xa_data_wr,
  input  logic [DW-1:0] xa_data_rd,
  output logic          busy,
  output logic [15:0]   wr_cnt,
  output logic [15:0]   rd_cnt
`ifdef SIF_INIT_CHECK_EN
  ,
  output logic          rsp_err,
  output logic [7:0]    err_cnt
`endif
);

  sif_init_state_e state_q, state_d;
  sif_cmd_t        cmd_in, head;
  logic [SIF_CMD_W-1:0] head_bits;
  logic            fifo_full, fifo_empty, push, pop;

  logic            cur_rd_q;
  logic [AW-1:0]   xa_addr_q;
  logic [DW-1:0]   xa_data_wr_q;
  logic [DW-1:0]   rsp_data_q;
  logic [AW-1:0]   rsp_addr_q;
  logic [15:0]     wr_cnt_q, rd_cnt_q;

  assign cmd_in    = '{rd: cmd_rd, addr: cmd_addr, data: cmd_data};
  assign head      = sif_cmd_t'(head_bits);
  assign cmd_ready = !fifo_full;
  assign push      = cmd_valid && cmd_ready;

  sif_cmd_fifo #(
    .DEPTH(CMD_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst    (rst),
    .push_i (push),
    .cmd_i  (cmd_in),
    .pop_i  (pop),
    .head_o (head_bits),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Every transition into ISSUE pops the head command.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (cur_rd_q) begin
          state_d = RD_WAIT;
        end else if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      RD_WAIT: state_d = RD_RSP;
      RD_RSP: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cur_rd_q     <= 1'b0;
      xa_addr_q    <= '0;
      xa_data_wr_q <= '0;
      rsp_data_q   <= '0;
      rsp_addr_q   <= '0;
      wr_cnt_q     <= '0;
      rd_cnt_q     <= '0;
    end else begin
      if (pop) begin
        cur_rd_q  <= head.rd;
        xa_addr_q <= head.addr;
        if (!head.rd) begin
          xa_data_wr_q <= head.data;
        end
      end
      if (state_q == ISSUE && !cur_rd_q) begin
        wr_cnt_q <= wr_cnt_q + 16'd1;
      end
      if (state_q == RD_WAIT) begin
        rsp_data_q <= xa_data_rd;
        rsp_addr_q <= xa_addr_q;
      end
      if (state_q == RD_RSP) begin
        rd_cnt_q <= rd_cnt_q + 16'd1;
      end
    end
  end

`ifdef SIF_INIT_CHECK_EN
  logic       err_q;
  logic [7:0] err_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      if (state_q == RD_WAIT) begin
        err_q <= (xa_data_rd != sif_scramble(xa_addr_q));
      end
      if (state_q == RD_RSP && err_q && err_cnt_q != 8'hFF) begin
        err_cnt_q <= err_cnt_q + 8'd1;
      end
    end
  end

  assign err_cnt = err_cnt_q;
`endif

  always_comb begin
    rsp_valid = (state_q == RD_RSP);
    xa_wr_s   = (state_q == ISSUE) && !cur_rd_q;
    xa_rd_s   = (state_q == ISSUE) && cur_rd_q;
    busy      = !fifo_empty || (state_q != IDLE);
`ifdef SIF_INIT_CHECK_EN
    rsp_err   = (state_q == RD_RSP) && err_q;
`endif
  end

  assign xa_addr    = xa_addr_q;
  assign xa_data_wr = xa_data_wr_q;
  assign rsp_data   = rsp_data_q;
  assign rsp_addr   = rsp_addr_q;
  assign wr_cnt     = wr_cnt_q;
  assign rd_cnt     = rd_cnt_q;

endmodule

// File: tb/tb_sif_initiator.sv
// Self-checking bench for sif_initiator: a SIF responder model, a
// transaction-level scoreboard checked every cycle, and directed scenarios.
module tb_sif_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_rd = 1'b0;
  logic [15:0] cmd_addr = '0;
  logic [15:0] cmd_data = '0;
  logic        rsp_valid;
  logic [15:0] rsp_data, rsp_addr;
  logic        xa_wr_s, xa_rd_s;
  logic [15:0] xa_addr, xa_data_wr;
  logic [15:0] xa_data_rd = '0;
  logic        busy;
  logic [15:0] wr_cnt, rd_cnt;
`ifdef SIF_INIT_CHECK_EN
  logic        rsp_err;
  logic [7:0]  err_cnt;
`endif

  always #5 clk = ~clk;

  sif_initiator #(.CMD_DEPTH(4), .AW(16), .DW(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_rd    (cmd_rd),
    .cmd_addr  (cmd_addr),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_addr  (rsp_addr),
    .xa_wr_s   (xa_wr_s),
    .xa_rd_s   (xa_rd_s),
    .xa_addr   (xa_addr),
    .xa_data_wr(xa_data_wr),
    .xa_data_rd(xa_data_rd),
    .busy      (busy),
    .wr_cnt    (wr_cnt),
    .rd_cnt    (rd_cnt)
`ifdef SIF_INIT_CHECK_EN
    ,
    .rsp_err   (rsp_err),
    .err_cnt   (err_cnt)
`endif
  );

  typedef struct {
    logic        rd;
    logic [15:0] addr;
    logic [15:0] data;
  } cmd_t;

  typedef struct {
    int          due;
    logic [15:0] addr;
    logic [15:0] data;
    logic        err;
  } rsp_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          last_acc = 0;
  int          last_wait = 0;
  logic        corrupt_en = 1'b0;

  cmd_t        exp_q[$];
  rsp_t        pend_q[$];
  logic [15:0] m_wr = '0, m_rd = '0, m_addr = '0, m_wdata = '0;
  logic [7:0]  m_err = '0;
  int          wr_cyc_q[$], rd_cyc_q[$], rsp_cyc_q[$];
  logic [15:0] rsp_data_log[$], rsp_addr_log[$];
  logic        rsp_err_log[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Target model: bits 7/8 picked up from bits 5/4, optional bit-0 fault.
  function automatic logic [15:0] scr(input logic [15:0] a);
    logic [15:0] r;
    r = a;
    if (a[4]) r[8] = ~r[8];
    if (a[5]) r[7] = ~r[7];
    return r;
  endfunction

  function automatic logic [15:0] resp_val(input logic [15:0] a);
    return scr(a) ^ ((corrupt_en && a == 16'h0463) ? 16'h0001 : 16'h0000);
  endfunction

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Responder: data valid only in the cycle after the read strobe.
  logic        resp_pend = 1'b0;
  logic [15:0] resp_pa = '0;
  initial forever begin
    @(negedge clk);
    xa_data_rd = resp_pend ? resp_val(resp_pa) : (16'hC3C3 ^ cyc[15:0]);
    resp_pend  = xa_rd_s;
    resp_pa    = xa_addr;
  end

  // Scoreboard compare process.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      pend_q.delete();
      m_wr = '0; m_rd = '0; m_addr = '0; m_wdata = '0; m_err = '0;
    end else begin
      logic exp_v;
      rsp_t r;
      cmd_t c;
      chk("busy", 32'(busy), 32'(exp_q.size() > 0 || pend_q.size() > 0));
      chk("strobe_overlap", 32'(xa_wr_s && xa_rd_s), 32'(0));
      chk("wr_cnt", 32'(wr_cnt), 32'(m_wr));
      chk("rd_cnt", 32'(rd_cnt), 32'(m_rd));
`ifdef SIF_INIT_CHECK_EN
      chk("err_cnt", 32'(err_cnt), 32'(m_err));
`endif
      exp_v = (pend_q.size() > 0) && (pend_q[0].due == cyc);
      chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
`ifdef SIF_INIT_CHECK_EN
      chk("rsp_err", 32'(rsp_err), 32'(exp_v && pend_q[0].err));
`endif
      if (exp_v) begin
        r = pend_q.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(r.data));
        chk("rsp_addr", 32'(rsp_addr), 32'(r.addr));
        rsp_cyc_q.push_back(cyc);
        rsp_data_log.push_back(rsp_data);
        rsp_addr_log.push_back(rsp_addr);
`ifdef SIF_INIT_CHECK_EN
        rsp_err_log.push_back(rsp_err);
`endif
        m_rd++;
        if (r.err && m_err != 8'hFF) m_err++;
      end else if (pend_q.size() > 0 && pend_q[0].due < cyc) begin
        void'(pend_q.pop_front());
      end
      if (xa_wr_s || xa_rd_s) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 32'(xa_wr_s || xa_rd_s), 32'(0));
        end else begin
          c = exp_q.pop_front();
          chk("strobe_type", 32'(xa_rd_s), 32'(c.rd));
          chk("xa_addr", 32'(xa_addr), 32'(c.addr));
          if (!c.rd) begin
            chk("xa_data_wr", 32'(xa_data_wr), 32'(c.data));
            m_wdata = c.data;
            m_wr++;
            wr_cyc_q.push_back(cyc);
          end else begin
            chk("xa_data_wr_rd_hold", 32'(xa_data_wr), 32'(m_wdata));
            r.due  = cyc + 2;
            r.addr = c.addr;
            r.data = resp_val(c.addr);
            r.err  = (resp_val(c.addr) != scr(c.addr));
            pend_q.push_back(r);
            rd_cyc_q.push_back(cyc);
          end
          m_addr = c.addr;
        end
      end else begin
        chk("xa_addr_hold", 32'(xa_addr), 32'(m_addr));
        chk("xa_data_wr_hold", 32'(xa_data_wr), 32'(m_wdata));
      end
    end
  end

  // Called at a negedge; returns at a negedge one cycle after acceptance.
  task automatic push(input logic rd, input logic [15:0] a, input logic [15:0] d);
    int   n;
    cmd_t c;
    n = 0;
    cmd_valid = 1'b1; cmd_rd = rd; cmd_addr = a; cmd_data = d;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    last_wait = n;
    if (!cmd_ready) begin
      chk("push_timeout", 32'(cmd_ready), 32'(1));
      @(negedge clk);
    end else begin
      last_acc = cyc;
      @(posedge clk);
      c.rd = rd; c.addr = a; c.data = d;
      exp_q.push_back(c);
      @(negedge clk);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk("idle_timeout", 32'(busy), 32'(0));
    @(negedge clk);
  endtask

  task automatic clear_logs();
    wr_cyc_q.delete(); rd_cyc_q.delete(); rsp_cyc_q.delete();
    rsp_data_log.delete(); rsp_addr_log.delete(); rsp_err_log.delete();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished cycle=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    int   early;
    logic saw_stall;
    logic rsp_seen;

    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_strobes", 32'({xa_wr_s, xa_rd_s, rsp_valid}), 32'(0));
    chk("rst_xa_addr", 32'(xa_addr), 32'(0));
    chk("rst_cnts", 32'({wr_cnt, rd_cnt}), 32'(0));
    rst = 1'b0;
    @(negedge clk);

    // Reset while a read is in flight.
    push(1'b1, 16'h05DE, 16'h0000);
    n = 0;
    while (!xa_rd_s && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rd_strobe_before_rst", 32'(xa_rd_s), 32'(1));
    rst = 1'b1;
    rsp_seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      rsp_seen |= rsp_valid;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      rsp_seen |= rsp_valid;
    end
    chk("no_rsp_after_rst", 32'(rsp_seen), 32'(0));
    chk("rst2_outputs", 32'({cmd_ready, busy, xa_wr_s, xa_rd_s}), 32'(4'b1000));
    chk("rst2_xa", 32'({xa_addr, xa_data_wr}), 32'(0));
    chk("rst2_rsp", 32'({rsp_data, rsp_addr}), 32'(0));
    chk("rst2_cnts", 32'({wr_cnt, rd_cnt}), 32'(0));

    // Single write.
    clear_logs();
    push(1'b0, 16'h1234, 16'hBEEF);
    n = last_acc;
    wait_idle(20);
    chk("wr_strobe_count", 32'(wr_cyc_q.size()), 32'(1));
    chk("wr_latency", 32'((wr_cyc_q.size() > 0) ? wr_cyc_q[0] - n : -1), 32'(2));
    chk("wr_cnt_1", 32'(wr_cnt), 32'(1));
    chk("wr_hold_addr", 32'(xa_addr), 32'(16'h1234));
    chk("wr_hold_data", 32'(xa_data_wr), 32'(16'hBEEF));

    // Three reads against the responder.
    clear_logs();
    push(1'b1, 16'h05DE, 16'h0000);
    push(1'b1, 16'h0463, 16'h0000);
    push(1'b1, 16'h1305, 16'h0000);
    wait_idle(40);
    chk("rsp_count", 32'(rsp_data_log.size()), 32'(3));
    if (rsp_data_log.size() == 3 && rd_cyc_q.size() == 3) begin
      chk("rsp0_data", 32'(rsp_data_log[0]), 32'(16'h04DE));
      chk("rsp1_data", 32'(rsp_data_log[1]), 32'(16'h04E3));
      chk("rsp2_data", 32'(rsp_data_log[2]), 32'(16'h1305));
      chk("rsp1_addr", 32'(rsp_addr_log[1]), 32'(16'h0463));
      for (int i = 0; i < 3; i++) chk("rsp_latency", 32'(rsp_cyc_q[i] - rd_cyc_q[i]), 32'(2));
      chk("rd_bus_span", 32'(rd_cyc_q[1] - rd_cyc_q[0]), 32'(3));
    end
    chk("rd_cnt_3", 32'(rd_cnt), 32'(3));
    chk("xa_data_wr_after_reads", 32'(xa_data_wr), 32'(16'hBEEF));

    // Fill the FIFO behind two reads, then drain six writes back-to-back.
    clear_logs();
    push(1'b1, 16'h0010, 16'h0000);
    push(1'b1, 16'h0020, 16'h0000);
    early = 0;
    saw_stall = 1'b0;
    for (int i = 0; i < 6; i++) begin
      push(1'b0, 16'h0100 + 16'(i), 16'h5000 + 16'(i));
      if (last_wait > 0) saw_stall = 1'b1;
      if (!saw_stall) early++;
    end
    wait_idle(40);
    chk("full_stall_seen", 32'(saw_stall), 32'(1));
    chk("accepted_before_full", 32'(early), 32'(4));
    chk("full_wr_count", 32'(wr_cyc_q.size()), 32'(6));
    chk("full_wr_b2b", 32'((wr_cyc_q.size() == 6) ? wr_cyc_q[5] - wr_cyc_q[0] : -1), 32'(5));
    chk("full_last_data", 32'(xa_data_wr), 32'(16'h5005));

    // Write, read, write ordering.
    clear_logs();
    push(1'b0, 16'h0200, 16'h1111);
    push(1'b1, 16'h05DE, 16'h0000);
    push(1'b0, 16'h0300, 16'h2222);
    wait_idle(40);
    chk("mixed_wr_count", 32'(wr_cyc_q.size()), 32'(2));
    chk("mixed_wr2_after_rsp",
        32'((wr_cyc_q.size() == 2 && rsp_cyc_q.size() == 1) ? wr_cyc_q[1] - rsp_cyc_q[0] : -1),
        32'(1));
    chk("mixed_final_data", 32'(xa_data_wr), 32'(16'h2222));

`ifdef SIF_INIT_CHECK_EN
    clear_logs();
    corrupt_en = 1'b1;
    push(1'b1, 16'h0463, 16'h0000);
    push(1'b1, 16'h1305, 16'h0000);
    wait_idle(40);
    corrupt_en = 1'b0;
    chk("err_log_count", 32'(rsp_err_log.size()), 32'(2));
    if (rsp_err_log.size() == 2) begin
      chk("rsp_err_bad", 32'(rsp_err_log[0]), 32'(1));
      chk("rsp_err_clean", 32'(rsp_err_log[1]), 32'(0));
      chk("err_rsp_data", 32'(rsp_data_log[0]), 32'(16'h04E2));
    end
    chk("err_cnt_1", 32'(err_cnt), 32'(1));
`endif

    // wr_cnt wrap after 65535 writes from a fresh reset.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    clear_logs();
    for (int i = 0; i < 65535; i++) begin
      push(1'b0, 16'(i), ~16'(i));
    end
    wait_idle(100);
    chk("wr_cnt_ffff", 32'(wr_cnt), 32'(16'hFFFF));
    clear_logs();
    push(1'b0, 16'hFFFF, 16'h0000);
    wait_idle(20);
    chk("wr_cnt_wrap", 32'(wr_cnt), 32'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
